// File: rtl/uart_cmd_parser.sv
// Byte-level command parser: UART byte stream in, one register bus transaction and one response byte out.
// Optional inter-byte frame timeout is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_en,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rd_valid,
    output logic       rx_overrun,
    output logic       frame_abort,
    output logic [2:0] dbg_state
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RESP     = 3'd4,
        S_TX_GUARD = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       is_write_q, is_write_d;
    logic [7:0] resp_q, resp_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_en_q, tx_en_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       ovr_q, ovr_d;
    logic       timeout_hit;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        resp_d     = resp_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        ovr_d      = ovr_q;
`ifdef UART_CMD_TIMEOUT_EN
        abort_d    = 1'b0;
        cnt_d      = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_en) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_write_d = (rx_data == OP_WRITE);
                        state_d    = S_GET_ADDR;
                    end else begin
                        resp_d  = RSP_NAK;
                        state_d = S_RESP;
                    end
                end
            end
            S_GET_ADDR, S_GET_DATA: begin
                // An arriving byte beats an expiring timer in the same cycle.
                if (rx_en && state_q == S_GET_ADDR) begin
                    addr_d = rx_data;
                    if (is_write_q) begin
                        state_d = S_GET_DATA;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = S_RD_WAIT;
                    end
                end else if (rx_en) begin
                    wdata_d = rx_data;
                    wr_d    = 1'b1;
                    resp_d  = RSP_ACK;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
`ifdef UART_CMD_TIMEOUT_EN
                    abort_d = 1'b1;
`endif
                end else begin
`ifdef UART_CMD_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RD_WAIT: begin
                if (reg_rd_valid) begin
                    resp_d  = reg_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!tx_busy) begin
                    tx_data_d = resp_q;
                    tx_en_d   = 1'b1;
                    state_d   = S_TX_GUARD;
                end
            end
            S_TX_GUARD: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (rx_en && (state_q == S_RD_WAIT || state_q == S_RESP || state_q == S_TX_GUARD)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            resp_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            resp_q     <= resp_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end
    assign frame_abort = abort_q;
`else
    assign frame_abort = 1'b0;
`endif

    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_wr     = wr_q;
    assign reg_rd     = rd_q;
    assign rx_overrun = ovr_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser between the management UART receiver/transmitter and the management register bus. Consumes the UART's received byte stream (`rx_data`/`rx_en`), decodes single-byte-opcode read and write frames, issues one register bus transaction per frame, and returns a one-byte response to the UART transmitter (`tx_data`/`tx_en`). Replaces the fixed 0xAA→0x69 echo logic in the management FPGA top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 2500000, inter-byte timeout in clocks (100 ms at 25 MHz); only used with the timeout macro defined.

Ports:
- `clk`  in  1  system clock (25 MHz in the management FPGA)
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `rx_data`  in  8  received byte from UART
- `rx_en`  in  1  one-cycle strobe, `rx_data` valid
- `tx_busy`  in  1  UART transmitter active (`txactive`)
- `tx_data`  out  8  response byte to UART
- `tx_en`  out  1  one-cycle transmit strobe
- `reg_addr`  out  8  register address
- `reg_wdata`  out  8  write data
- `reg_wr`  out  1  one-cycle write strobe
- `reg_rd`  out  1  one-cycle read strobe
- `reg_rdata`  in  8  read data
- `reg_rd_valid`  in  1  one-cycle strobe, `reg_rdata` valid
- `rx_overrun`  out  1  sticky: a byte arrived while parser busy
- `frame_abort`  out  1  one-cycle pulse: frame discarded by timeout

## Operation
- Frames: write = 0x57, addr, data; read = 0x52, addr. Responses: write → 0x06 (ACK); read → read data byte; unknown opcode → 0x15 (NAK).
- States: IDLE, GET_ADDR, GET_DATA, RD_WAIT, RESP, TX_GUARD.
- IDLE: on `rx_en`: 0x57 or 0x52 → latch opcode, GET_ADDR; any other byte → latch response 0x15, RESP.
- GET_ADDR: on `rx_en` latch `reg_addr`; write → GET_DATA; read → assert `reg_rd` next cycle, RD_WAIT.
- GET_DATA: on `rx_en` latch `reg_wdata`, assert `reg_wr` next cycle, latch response 0x06, RESP.
- RD_WAIT: on `reg_rd_valid` latch `reg_rdata` as response, RESP. Waits indefinitely; `reg_rd_valid` outside RD_WAIT ignored.
- RESP: when `tx_busy` low, drive `tx_data`=response, pulse `tx_en`, go TX_GUARD; while `tx_busy` high, hold.
- TX_GUARD: one cycle (lets UART raise `tx_busy`), then IDLE.
- `rx_en` in RD_WAIT, RESP or TX_GUARD: byte dropped, `rx_overrun` set; cleared only by `rst`.
- `reg_addr`/`reg_wdata` hold last latched values between frames.

## Timing
- All outputs registered. Reset values: `tx_data`=0, `tx_en`=0, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `rx_overrun`=0, `frame_abort`=0; state IDLE.
- Write: data byte `rx_en` at cycle N → `reg_wr` high at N+1 (addr/wdata stable) → `tx_en` at N+2 if `tx_busy` low.
- Read: addr byte `rx_en` at N → `reg_rd` high at N+1; `reg_rd_valid` at M ≥ N+1 → `tx_en` with data at M+2.
- NAK: bad opcode `rx_en` at N → `tx_en` at N+2.
- `reg_rd_valid` in the same cycle as `reg_rd` is accepted.
- `rst` mid-frame: outputs return to reset values immediately; any partial frame is discarded without a bus transaction or response.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined: counter of width $clog2(TIMEOUT_CYCLES+1) cleared on every accepted `rx_en`, increments in GET_ADDR/GET_DATA; on reaching `TIMEOUT_CYCLES` → IDLE, `frame_abort` pulses one cycle, no response, no bus strobe. `rx_en` in the expiry cycle wins: byte accepted, counter cleared.
- Not defined: no counter; GET_ADDR/GET_DATA wait indefinitely; `frame_abort` tied 0.

## Test plan
- Write: bytes 0x57, 0x12, 0xA5 → `reg_wr` one cycle with `reg_addr`=0x12, `reg_wdata`=0xA5; then `tx_en` with 0x06.
- Read: 0x52, 0x34; bench returns `reg_rdata`=0xC3 three cycles after `reg_rd` → single `tx_en` with 0xC3 two cycles after `reg_rd_valid`.
- Bad opcode 0xAA → `tx_en` with 0x15 at N+2, no `reg_rd`/`reg_wr`; next 0x52 frame parsed normally.
- `tx_busy` held high 50 cycles during RESP → `tx_en` delayed until cycle after `tx_busy` falls; byte sent during RESP → dropped, `rx_overrun`=1.
- `UART_CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: 0x57, 0x12, then 150-cycle gap → `frame_abort` pulse, no strobes, no `tx_en`; following 0x52, 0x12 frame completes.
- `rst` asserted in RD_WAIT → all outputs 0 same cycle; late `reg_rd_valid` after release produces no `tx_en`.
